// File: rtl/toy_bus_slv_endpoint.sv
// toy_bus_slv_endpoint: target-side bus endpoint with a registered memory request stage, in-order tag FIFO and registered ack stage.
// Optional macro TOY_BUS_SLV_TGT_CHECK_EN drops misrouted requests and raises a sticky err_tgt_mismatch.
module toy_bus_slv_endpoint #(
    parameter logic [3:0] NODE_ID   = 4'd2,
    parameter int         OST_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_req_vld,
    output logic         in0_req_rdy,
    input  logic [31:0]  in0_req_addr,
    input  logic [255:0] in0_req_data,
    input  logic [31:0]  in0_req_strb,
    input  logic         in0_req_opcode,
    input  logic [3:0]   in0_req_src_id,
    input  logic [3:0]   in0_req_tgt_id,
    input  logic [31:0]  in0_req_sideband,
    output logic         in0_ack_vld,
    input  logic         in0_ack_rdy,
    output logic         in0_ack_opcode,
    output logic [255:0] in0_ack_data,
    output logic [31:0]  in0_ack_sideband,
    output logic [3:0]   in0_ack_src_id,
    output logic [3:0]   in0_ack_tgt_id,
    output logic         mem_req_vld,
    input  logic         mem_req_rdy,
    output logic [31:0]  mem_req_addr,
    output logic [255:0] mem_req_data,
    output logic [31:0]  mem_req_strb,
    output logic         mem_req_opcode,
    input  logic         mem_ack_vld,
    output logic         mem_ack_rdy,
    input  logic [255:0] mem_ack_data,
    output logic         err_tgt_mismatch
);
    localparam int AW = $clog2(OST_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(OST_DEPTH);

    logic [AW:0]   r_ost_cnt;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic          r_tag_op  [OST_DEPTH];
    logic [3:0]    r_tag_src [OST_DEPTH];
    logic [31:0]   r_tag_sb  [OST_DEPTH];
    logic          r_req_vld, r_req_op;
    logic [31:0]   r_req_addr, r_req_strb;
    logic [255:0]  r_req_data;
    logic          r_ack_vld, r_ack_op;
    logic [255:0]  r_ack_data;
    logic [31:0]   r_ack_sb;
    logic [3:0]    r_ack_src, r_ack_tgt;
    logic          r_err;
    logic          w_req_hs, w_push, w_ack_hs, w_pop, w_tgt_ok;

`ifdef TOY_BUS_SLV_TGT_CHECK_EN
    assign w_tgt_ok = (in0_req_tgt_id == NODE_ID);
`else
    logic w_unused_tgt;
    assign w_tgt_ok     = 1'b1;
    assign w_unused_tgt = ^in0_req_tgt_id;
`endif

    assign in0_req_rdy = (!r_req_vld | mem_req_rdy) & (r_ost_cnt < FULL);
    assign mem_ack_rdy = !r_ack_vld | in0_ack_rdy;
    assign w_req_hs    = in0_req_vld & in0_req_rdy;
    assign w_push      = w_req_hs & w_tgt_ok;
    assign w_ack_hs    = mem_ack_vld & mem_ack_rdy;
    assign w_pop       = w_ack_hs & (r_ost_cnt != '0);

    assign mem_req_vld      = r_req_vld;
    assign mem_req_addr     = r_req_addr;
    assign mem_req_data     = r_req_data;
    assign mem_req_strb     = r_req_strb;
    assign mem_req_opcode   = r_req_op;
    assign in0_ack_vld      = r_ack_vld;
    assign in0_ack_opcode   = r_ack_op;
    assign in0_ack_data     = r_ack_data;
    assign in0_ack_sideband = r_ack_sb;
    assign in0_ack_src_id   = r_ack_src;
    assign in0_ack_tgt_id   = r_ack_tgt;
    assign err_tgt_mismatch = r_err;

    // Request stage: load on a forwarded handshake, drain when memory takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_vld  <= 1'b0;
            r_req_op   <= 1'b0;
            r_req_addr <= '0;
            r_req_data <= '0;
            r_req_strb <= '0;
        end else begin
            r_req_vld <= w_push | (r_req_vld & !mem_req_rdy);
            if (w_push) begin
                r_req_op   <= in0_req_opcode;
                r_req_addr <= in0_req_addr;
                r_req_data <= in0_req_data;
                r_req_strb <= in0_req_strb;
            end
        end
    end

    // Tag FIFO and outstanding counter; a pop with nothing outstanding is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ost_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            for (int i = 0; i < OST_DEPTH; i++) begin
                r_tag_op[i]  <= 1'b0;
                r_tag_src[i] <= '0;
                r_tag_sb[i]  <= '0;
            end
        end else begin
            r_ost_cnt <= r_ost_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_push) begin
                r_tag_op[r_wr_ptr]  <= in0_req_opcode;
                r_tag_src[r_wr_ptr] <= in0_req_src_id;
                r_tag_sb[r_wr_ptr]  <= in0_req_sideband;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Ack stage: completion merged with its tag, IDs swapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_vld  <= 1'b0;
            r_ack_op   <= 1'b0;
            r_ack_data <= '0;
            r_ack_sb   <= '0;
            r_ack_src  <= '0;
            r_ack_tgt  <= '0;
        end else begin
            r_ack_vld <= w_pop | (r_ack_vld & !in0_ack_rdy);
            if (w_pop) begin
                r_ack_op   <= r_tag_op[r_rd_ptr];
                r_ack_data <= mem_ack_data;
                r_ack_sb   <= r_tag_sb[r_rd_ptr];
                r_ack_src  <= NODE_ID;
                r_ack_tgt  <= r_tag_src[r_rd_ptr];
            end
        end
    end

`ifdef TOY_BUS_SLV_TGT_CHECK_EN
    // Sticky misroute flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= r_err | (w_req_hs & !w_tgt_ok);
    end
`else
    assign r_err = 1'b0;
`endif
endmodule

// File: tb/tb_toy_bus_slv_endpoint.sv
// tb_toy_bus_slv_endpoint: scoreboard bench for toy_bus_slv_endpoint with a latency-controlled memory model.
module tb_toy_bus_slv_endpoint;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in0_req_vld = 1'b0, in0_req_rdy;
    logic [31:0]  in0_req_addr = '0, in0_req_strb = '0, in0_req_sideband = '0;
    logic [255:0] in0_req_data = '0;
    logic         in0_req_opcode = 1'b0;
    logic [3:0]   in0_req_src_id = '0, in0_req_tgt_id = '0;
    logic         in0_ack_vld, in0_ack_rdy = 1'b1, in0_ack_opcode;
    logic [255:0] in0_ack_data;
    logic [31:0]  in0_ack_sideband;
    logic [3:0]   in0_ack_src_id, in0_ack_tgt_id;
    logic         mem_req_vld, mem_req_rdy = 1'b1, mem_req_opcode;
    logic [31:0]  mem_req_addr, mem_req_strb;
    logic [255:0] mem_req_data;
    logic         mem_ack_vld = 1'b0, mem_ack_rdy;
    logic [255:0] mem_ack_data = '0;
    logic         err_tgt_mismatch;

    typedef struct { logic [31:0] addr; logic [255:0] data; logic [31:0] strb; logic op; } mreq_t;
    typedef struct { logic op; logic [255:0] data; logic [31:0] sb; logic [3:0] tgt; } ack_t;
    typedef struct { logic [255:0] data; int due; } pend_t;

    mreq_t memx_q[$];
    ack_t  ack_q[$];
    pend_t pend_q[$];
    int    ack_cyc[$];
    int    n_tests = 0, n_fail = 0, cyc = 0, mem_lat = 0, w = 0, wsum = 0;
    bit    mem_en = 1'b1;

    toy_bus_slv_endpoint #(.NODE_ID(4'd2), .OST_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy), .in0_req_addr(in0_req_addr),
        .in0_req_data(in0_req_data), .in0_req_strb(in0_req_strb), .in0_req_opcode(in0_req_opcode),
        .in0_req_src_id(in0_req_src_id), .in0_req_tgt_id(in0_req_tgt_id), .in0_req_sideband(in0_req_sideband),
        .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy), .in0_ack_opcode(in0_ack_opcode),
        .in0_ack_data(in0_ack_data), .in0_ack_sideband(in0_ack_sideband), .in0_ack_src_id(in0_ack_src_id),
        .in0_ack_tgt_id(in0_ack_tgt_id), .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_strb(mem_req_strb),
        .mem_req_opcode(mem_req_opcode), .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy),
        .mem_ack_data(mem_ack_data), .err_tgt_mismatch(err_tgt_mismatch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mdata(input logic [31:0] a);
        return (a == 32'h8000_0040) ? 256'h1234 : {8{a ^ 32'hA5A5_0F0F}};
    endfunction

    // Memory model: drives the head completion once its latency has elapsed.
    always @(posedge clk) begin
        #2;
        if (mem_en && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_ack_vld  = 1'b1;
            mem_ack_data = pend_q[0].data;
        end else begin
            mem_ack_vld  = 1'b0;
        end
    end

    // Monitor: checks memory requests and acks against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ack_vld && mem_ack_rdy && pend_q.size() > 0)
                void'(pend_q.pop_front());
            if (mem_req_vld && mem_req_rdy) begin
                if (memx_q.size() == 0) begin
                    chk("unexp_mreq", 1'b1, 1'b0);
                end else begin
                    mreq_t e;
                    e = memx_q.pop_front();
                    chk("mreq_addr", mem_req_addr, e.addr);
                    chk("mreq_data", mem_req_data, e.data);
                    chk("mreq_strb", mem_req_strb, e.strb);
                    chk("mreq_op", mem_req_opcode, e.op);
                end
                pend_q.push_back('{mdata(mem_req_addr), cyc + mem_lat});
            end
            if (in0_ack_vld && in0_ack_rdy) begin
                if (ack_q.size() == 0) begin
                    chk("unexp_ack", in0_ack_vld, 1'b0);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    chk("ack_op", in0_ack_opcode, a.op);
                    chk("ack_data", in0_ack_data, a.data);
                    chk("ack_sb", in0_ack_sideband, a.sb);
                    chk("ack_src", in0_ack_src_id, 4'd2);
                    chk("ack_tgt", in0_ack_tgt_id, a.tgt);
                end
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic op, input logic [3:0] src, input logic [3:0] tgt,
                        input logic [31:0] sb, output int waits);
        bit fwd;
        in0_req_addr     = a;
        in0_req_data     = {8{a + 32'h1111_0000}};
        in0_req_strb     = a ^ 32'hF0F0_0F0F;
        in0_req_opcode   = op;
        in0_req_src_id   = src;
        in0_req_tgt_id   = tgt;
        in0_req_sideband = sb;
        in0_req_vld      = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in0_req_rdy) break;
            waits++;
            if (waits > 100) begin
                chk("req_timeout", 1'b0, 1'b1);
                break;
            end
        end
`ifdef TOY_BUS_SLV_TGT_CHECK_EN
        fwd = (tgt == 4'd2);
`else
        fwd = 1'b1;
`endif
        if (in0_req_rdy && fwd) begin
            memx_q.push_back('{a, in0_req_data, in0_req_strb, op});
            ack_q.push_back('{op, mdata(a), sb, src});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        in0_req_vld = 1'b0;
        while ((ack_q.size() > 0 || memx_q.size() > 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain", ack_q.size() + memx_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mreq_vld", mem_req_vld, 1'b0);
        chk("rst_ack_vld", in0_ack_vld, 1'b0);
        chk("rst_req_rdy", in0_req_rdy, 1'b1);
        chk("rst_err", err_tgt_mismatch, 1'b0);
        chk("rst_mreq_addr", mem_req_addr, 32'h0);
        chk("rst_ack_data", in0_ack_data, 256'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mem_lat = 3;
        send(32'h8000_0040, 1'b0, 4'd0, 4'd2, 32'hA5, w);
        chk("rd_mreq_vld_n1", mem_req_vld, 1'b1);
        drain();

        mem_lat = 0;
        ack_cyc.delete();
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + 32'(i * 64), 1'b1, 4'(i), 4'd2, 32'hC000 + 32'(i), w);
            wsum += w;
        end
        drain();
        chk("b2b_stall", wsum, 0);
        chk("b2b_cnt", ack_cyc.size(), 8);
        chk("b2b_span", ack_cyc[7] - ack_cyc[0], 7);

        mem_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h200 + 32'(i * 16), 1'b0, 4'd1, 4'd2, 32'(i), w);
            chk("ost_accept", w, 0);
        end
        in0_req_addr = 32'h240;
        @(negedge clk);
        chk("ost_full_rdy", in0_req_rdy, 1'b0);
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        @(negedge clk);
        chk("ost_full_rdy2", in0_req_rdy, 1'b0);
        @(posedge clk);
        #1;
        send(32'h240, 1'b0, 4'd1, 4'd2, 32'h4, w);
        chk("ost_fifth_next", w, 0);
        drain();

        in0_ack_rdy = 1'b0;
        send(32'h300, 1'b0, 4'd6, 4'd2, 32'hB0, w);
        send(32'h340, 1'b1, 4'd7, 4'd2, 32'hB1, w);
        in0_req_vld = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_mem_ack_rdy", mem_ack_rdy, 1'b0);
        chk("bp_mem_ack_vld", mem_ack_vld, 1'b1);
        chk("bp_ack_vld", in0_ack_vld, 1'b1);
        chk("bp_ack_data", in0_ack_data, ack_q[0].data);
        repeat (3) @(negedge clk);
        chk("bp_ack_data_hold", in0_ack_data, ack_q[0].data);
        chk("bp_ack_sb_hold", in0_ack_sideband, ack_q[0].sb);
        @(posedge clk);
        #1;
        in0_ack_rdy = 1'b1;
        drain();

        send(32'h400, 1'b1, 4'd5, 4'd3, 32'hDD, w);
        in0_req_vld = 1'b0;
        repeat (4) @(negedge clk);
`ifdef TOY_BUS_SLV_TGT_CHECK_EN
        chk("mis_mreq_vld", mem_req_vld, 1'b0);
        chk("mis_ack_vld", in0_ack_vld, 1'b0);
        chk("mis_err", err_tgt_mismatch, 1'b1);
        @(posedge clk);
        #1;
        send(32'h440, 1'b0, 4'd5, 4'd2, 32'hDE, w);
        drain();
        chk("mis_err_sticky", err_tgt_mismatch, 1'b1);
`else
        @(posedge clk);
        #1;
        drain();
        chk("mis_err_tied", err_tgt_mismatch, 1'b0);
`endif

        mem_en = 1'b0;
        send(32'h500, 1'b1, 4'd8, 4'd2, 32'hE0, w);
        send(32'h540, 1'b1, 4'd9, 4'd2, 32'hE1, w);
        in0_req_vld = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mreq_vld", mem_req_vld, 1'b0);
        chk("arst_ack_vld", in0_ack_vld, 1'b0);
        chk("arst_req_rdy", in0_req_rdy, 1'b1);
        ack_q.delete();
        memx_q.delete();
        pend_q.delete();
        mem_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_no_ack", in0_ack_vld, 1'b0);
        send(32'h600, 1'b0, 4'd3, 4'd2, 32'hF0, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
